// File: rtl/im_pkg.sv
// im_pkg: shared definitions for the instruction-memory side of the core.
//   - IM window (base byte address, size in words)
//   - exception handler entry, shared with the CP0/PC logic
//   - response-state encoding of the IM port arbiter
//   - error data word and DBG starvation limit
package im_pkg;

  localparam logic [31:0] IM_BASE      = 32'h0000_3000;
  localparam int unsigned IM_WORDS     = 4096;
  localparam logic [31:0] HANDLER_ADDR = 32'h0000_4180;

  // Data returned with an error response: MIPS nop.
  localparam logic [31:0] ERR_WORD     = 32'h0000_0000;

  // Consecutive lost cycles after which a waiting DBG request is forced through.
  localparam int unsigned STARVE_MAX   = 4;
  localparam int unsigned STARVE_W     = $clog2(STARVE_MAX + 1);

  // Which requester receives the response presented this cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RSP_IF  = 2'd1,
    RSP_DBG = 2'd2
  } rsp_state_e;

endpackage : im_pkg

// File: rtl/im_addr_check.sv
// im_addr_check: combinational alignment/range check of a byte address
// against a word-addressed memory window [BASE, BASE + 4*WORDS - 1].
//   addr  in  32  byte address to check
//   err   out 1   address misaligned or outside the window
module im_addr_check
  import im_pkg::*;
#(
  parameter logic [31:0] BASE  = IM_BASE,
  parameter int unsigned WORDS = IM_WORDS
) (
  input  logic [31:0] addr,
  output logic        err
);

  localparam logic [32:0] WINDOW_BYTES = 33'(WORDS) << 2;

  // Offset is formed in 33 bits so an address near the top of the 32-bit
  // space cannot wrap back into the window.
  logic [32:0] offset;

  assign offset = {1'b0, addr} - {1'b0, BASE};
  assign err    = (addr[1:0] != 2'b00) | (addr < BASE) | (offset >= WINDOW_BYTES);

endmodule : im_addr_check

// File: rtl/im_port_arbiter.sv
// im_port_arbiter: shares the single combinational IM read port between the
// fetch stage (IF) and the debug/loader port (DBG).
//   clk, rst_n                      clock, async active-low reset
//   if_req_valid/addr, if_req_ready IF request and its grant (combinational)
//   if_rsp_valid/data/err           IF response, one cycle after the grant
//   flush                           IF redirect; kills the IF grant this cycle
//   dbg_req_valid/addr, dbg_req_ready  DBG request and its grant
//   dbg_rsp_valid/data/err          DBG response, one cycle after the grant
//   im_addr, im_data                IM address out / IM data in
// IF normally wins; DBG is forced through after STARVE_MAX consecutive losses.
module im_port_arbiter
  import im_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,

  input  logic        if_req_valid,
  input  logic [31:0] if_req_addr,
  output logic        if_req_ready,
  output logic        if_rsp_valid,
  output logic [31:0] if_rsp_data,
  output logic        if_rsp_err,
  input  logic        flush,

  input  logic        dbg_req_valid,
  input  logic [31:0] dbg_req_addr,
  output logic        dbg_req_ready,
  output logic        dbg_rsp_valid,
  output logic [31:0] dbg_rsp_data,
  output logic        dbg_rsp_err,

  output logic [31:0] im_addr,
  input  logic [31:0] im_data
);

  rsp_state_e          state_q,     state_d;
  logic [STARVE_W-1:0] starve_q,    starve_d;
  logic [31:0]         addr_hold_q, addr_hold_d;
  logic [31:0]         if_data_q,   if_data_d;
  logic                if_err_q,    if_err_d;
  logic [31:0]         dbg_data_q,  dbg_data_d;
  logic                dbg_err_q,   dbg_err_d;

  logic        if_ok;
  logic        force_dbg;
  logic        if_gnt;
  logic        dbg_gnt;
  logic [31:0] gnt_addr;
  logic        gnt_err;
  logic [31:0] gnt_word;

  // Grant arbitration. Grants are gated by rst_n so neither ready is
  // asserted while the block is held in reset.
  // NOTE: every signal assigned in an always_comb gets a default at the top;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    if_ok     = if_req_valid & ~flush;
    force_dbg = dbg_req_valid & (starve_q == STARVE_W'(STARVE_MAX));
    if_gnt    = 1'b0;
    dbg_gnt   = 1'b0;
    if (rst_n) begin
      if (force_dbg)          dbg_gnt = 1'b1;
      else if (if_ok)         if_gnt  = 1'b1;
      else if (dbg_req_valid) dbg_gnt = 1'b1;
    end
  end

  assign gnt_addr      = dbg_gnt ? dbg_req_addr : if_req_addr;
  // Without a grant the last granted address is held so IM does not toggle.
  assign im_addr       = (if_gnt | dbg_gnt) ? gnt_addr : addr_hold_q;
  assign if_req_ready  = if_gnt;
  assign dbg_req_ready = dbg_gnt;

  im_addr_check #(
    .BASE  (IM_BASE),
    .WORDS (IM_WORDS)
  ) u_addr_check (
    .addr (gnt_addr),
    .err  (gnt_err)
  );

  assign gnt_word = gnt_err ? ERR_WORD : im_data;

  // Next-state: response owner, starvation count, held address and the
  // per-requester response payloads (which hold while not valid).
  always_comb begin
    state_d     = IDLE;
    starve_d    = '0;
    addr_hold_d = addr_hold_q;
    if_data_d   = if_data_q;
    if_err_d    = if_err_q;
    dbg_data_d  = dbg_data_q;
    dbg_err_d   = dbg_err_q;

    if (if_gnt) begin
      state_d     = RSP_IF;
      addr_hold_d = gnt_addr;
      if_data_d   = gnt_word;
      if_err_d    = gnt_err;
    end else if (dbg_gnt) begin
      state_d     = RSP_DBG;
      addr_hold_d = gnt_addr;
      dbg_data_d  = gnt_word;
      dbg_err_d   = gnt_err;
    end

    // Count only cycles in which DBG waits and loses; saturate at the limit.
    if (dbg_req_valid && !dbg_gnt) begin
      if (starve_q == STARVE_W'(STARVE_MAX)) starve_d = starve_q;
      else                                   starve_d = starve_q + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      addr_hold_q <= '0;
      if_data_q   <= '0;
      if_err_q    <= 1'b0;
      dbg_data_q  <= '0;
      dbg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      addr_hold_q <= addr_hold_d;
      if_data_q   <= if_data_d;
      if_err_q    <= if_err_d;
      dbg_data_q  <= dbg_data_d;
      dbg_err_q   <= dbg_err_d;
    end
  end

  assign if_rsp_valid  = (state_q == RSP_IF);
  assign if_rsp_data   = if_data_q;
  assign if_rsp_err    = if_err_q;
  assign dbg_rsp_valid = (state_q == RSP_DBG);
  assign dbg_rsp_data  = dbg_data_q;
  assign dbg_rsp_err   = dbg_err_q;

endmodule : im_port_arbiter
